// File: rtl/router_pkt_reader_if.sv
// Bundle of FIFO-side and destination-side signals for one output channel reader.
// master: the reader (drives rd_en and the packet outputs).
// slave:  the environment (FIFO, synchronizer and destination).
interface router_pkt_reader_if #(
  parameter int CNT_W = 8
);
  logic             vld_out;
  logic [7:0]       dout;
  logic             soft_reset;
  logic             stall;
  logic             rd_en;
  logic [7:0]       pkt_data;
  logic             pkt_data_vld;
  logic             pkt_sop;
  logic             pkt_eop;
  logic [5:0]       pkt_len;
  logic             parity_err;
  logic [CNT_W-1:0] pkt_cnt;
  logic [CNT_W-1:0] err_cnt;

  modport master (
    input  vld_out, dout, soft_reset, stall,
    output rd_en, pkt_data, pkt_data_vld, pkt_sop, pkt_eop,
           pkt_len, parity_err, pkt_cnt, err_cnt
  );

  modport slave (
    output vld_out, dout, soft_reset, stall,
    input  rd_en, pkt_data, pkt_data_vld, pkt_sop, pkt_eop,
           pkt_len, parity_err, pkt_cnt, err_cnt
  );
endinterface

// File: rtl/router_pkt_reader.sv
// Destination-side packet reader for one router output FIFO.
// Issues registered reads, reassembles header/payload/parity, frames the bytes
// with SOP/EOP, checks parity and keeps saturating packet/error counters.
// Read data arrives on dout one cycle after rd_en; it is presented one cycle later.
module router_pkt_reader #(
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  router_pkt_reader_if.master    bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HDR  = 2'd1;
  localparam logic [1:0] BODY = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state_reg;
  logic             rd_en_reg;
  logic             in_flight_reg;   // dout carries a requested byte this cycle
  logic [6:0]       req_left_reg;    // reads still to issue (payload + parity)
  logic [6:0]       rcv_left_reg;    // bytes still to receive (payload + parity)
  logic [7:0]       xor_reg;
  logic [7:0]       data_reg;
  logic             vld_reg;
  logic             sop_reg;
  logic             eop_reg;
  logic [5:0]       len_reg;
  logic             perr_reg;
  logic [CNT_W-1:0] pkt_cnt_reg;
  logic [CNT_W-1:0] err_cnt_reg;

  logic       can_read;
  logic       last_byte;
  logic       par_bad;
  logic [6:0] rem_init;

  assign can_read  = bus.vld_out && !bus.stall;
  assign last_byte = (rcv_left_reg == 7'd1);
  assign par_bad   = (xor_reg != bus.dout);
  assign rem_init  = {1'b0, bus.dout[7:2]} + 7'd1;

  // Read sequencing: state machine, read strobe and byte bookkeeping
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      rd_en_reg     <= 1'b0;
      in_flight_reg <= 1'b0;
      req_left_reg  <= '0;
      rcv_left_reg  <= '0;
      xor_reg       <= '0;
    end else if (bus.soft_reset) begin
      // Abort: drop any requested byte and wait in IDLE for the FIFO to refill
      state_reg     <= IDLE;
      rd_en_reg     <= 1'b0;
      in_flight_reg <= 1'b0;
      req_left_reg  <= '0;
      rcv_left_reg  <= '0;
    end else begin
      in_flight_reg <= rd_en_reg;
      rd_en_reg     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (can_read) begin
            rd_en_reg <= 1'b1;
            state_reg <= HDR;
          end
        end
        HDR: begin
          if (in_flight_reg) begin
            req_left_reg <= rem_init;
            rcv_left_reg <= rem_init;
            xor_reg      <= bus.dout;
            state_reg    <= BODY;
          end
        end
        BODY: begin
          if (can_read && (req_left_reg != 7'd0)) begin
            rd_en_reg    <= 1'b1;
            req_left_reg <= req_left_reg - 7'd1;
          end
          if (in_flight_reg) begin
            rcv_left_reg <= rcv_left_reg - 7'd1;
            if (last_byte) begin
              state_reg <= DONE;
            end else begin
              xor_reg <= xor_reg ^ bus.dout;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Output path: present returned bytes with framing, parity check and statistics
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_reg    <= '0;
      vld_reg     <= 1'b0;
      sop_reg     <= 1'b0;
      eop_reg     <= 1'b0;
      len_reg     <= '0;
      perr_reg    <= 1'b0;
      pkt_cnt_reg <= '0;
      err_cnt_reg <= '0;
    end else if (bus.soft_reset) begin
      vld_reg  <= 1'b0;
      sop_reg  <= 1'b0;
      eop_reg  <= 1'b0;
      perr_reg <= 1'b0;
    end else begin
      vld_reg  <= 1'b0;
      sop_reg  <= 1'b0;
      eop_reg  <= 1'b0;
      perr_reg <= 1'b0;
      if (in_flight_reg && (state_reg == HDR)) begin
        data_reg <= bus.dout;
        vld_reg  <= 1'b1;
        sop_reg  <= 1'b1;
        len_reg  <= bus.dout[7:2];
      end
      if (in_flight_reg && (state_reg == BODY)) begin
        data_reg <= bus.dout;
        vld_reg  <= 1'b1;
        if (last_byte) begin
          eop_reg  <= 1'b1;
          perr_reg <= par_bad;
          if (pkt_cnt_reg != CNT_MAX) pkt_cnt_reg <= pkt_cnt_reg + CNT_ONE;
          if (par_bad && (err_cnt_reg != CNT_MAX)) err_cnt_reg <= err_cnt_reg + CNT_ONE;
        end
      end
    end
  end

  assign bus.rd_en        = rd_en_reg;
  assign bus.pkt_data     = data_reg;
  assign bus.pkt_data_vld = vld_reg;
  assign bus.pkt_sop      = sop_reg;
  assign bus.pkt_eop      = eop_reg;
  assign bus.pkt_len      = len_reg;
  assign bus.parity_err   = perr_reg;
  assign bus.pkt_cnt      = pkt_cnt_reg;
  assign bus.err_cnt      = err_cnt_reg;
endmodule

// File: tb/tb_router_pkt_reader.sv
// Self-checking bench for router_pkt_reader: a queue-based FIFO model feeds two
// readers (8-bit and 2-bit counters); a packet-level scoreboard predicts every
// presented byte, its framing, the parity verdict and the saturating counters.
module tb_router_pkt_reader;
  logic       clk;
  logic       rst;
  logic       soft_reset;
  logic       stall;
  logic       gate;
  logic [7:0] dout;
  logic       vld_out;
  int         fifo_cnt;

  router_pkt_reader_if #(.CNT_W(8)) bus8 ();
  router_pkt_reader_if #(.CNT_W(2)) bus2 ();

  assign bus8.vld_out    = vld_out;
  assign bus8.dout       = dout;
  assign bus8.soft_reset = soft_reset;
  assign bus8.stall      = stall;
  assign bus2.vld_out    = vld_out;
  assign bus2.dout       = dout;
  assign bus2.soft_reset = soft_reset;
  assign bus2.stall      = stall;

  router_pkt_reader #(.CNT_W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8.master));
  router_pkt_reader #(.CNT_W(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       perr;
    logic [5:0] len;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e_cur;
  logic [7:0] fifo_q[$];
  logic [7:0] pend_q[$];
  logic [7:0] pb[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         rd_cnt = 0;
  int         cnt_m = 0;
  int         err_m = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // FIFO model: one-cycle read latency, flushed by reset or soft_reset
  always @(posedge clk) begin
    if (!rst || soft_reset) begin
      fifo_q.delete();
      pend_q.delete();
    end else begin
      if (bus8.rd_en && fifo_q.size() > 0) dout <= fifo_q.pop_front();
      while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
    end
    fifo_cnt <= fifo_q.size();
  end

  always_comb vld_out = gate && (fifo_cnt != 0);

  // Scoreboard: compare every presented byte against the packet-level prediction
  always @(negedge clk) begin
    if (bus8.rd_en) rd_cnt++;
    if (bus8.pkt_data_vld) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", 32'(bus8.pkt_data_vld), 0);
      end else begin
        e_cur = exp_q.pop_front();
        chk("data", 32'(bus8.pkt_data), 32'(e_cur.data));
        chk("sop", 32'(bus8.pkt_sop), 32'(e_cur.sop));
        chk("eop", 32'(bus8.pkt_eop), 32'(e_cur.eop));
        chk("parity_err", 32'(bus8.parity_err), 32'(e_cur.perr));
        chk("vld_w2", 32'(bus2.pkt_data_vld), 1);
        if (e_cur.sop) chk("pkt_len", 32'(bus8.pkt_len), 32'(e_cur.len));
        if (e_cur.eop) begin
          cnt_m++;
          if (e_cur.perr) err_m++;
          chk("pkt_cnt8", 32'(bus8.pkt_cnt), sat(cnt_m, 255));
          chk("err_cnt8", 32'(bus8.err_cnt), sat(err_m, 255));
          chk("pkt_cnt2", 32'(bus2.pkt_cnt), sat(cnt_m, 3));
          chk("err_cnt2", 32'(bus2.err_cnt), sat(err_m, 3));
        end
      end
    end else begin
      chk("idle_flags", 32'({bus8.pkt_sop, bus8.pkt_eop, bus8.parity_err}), 0);
    end
    if (!rst) begin
      exp_q.delete();
      cnt_m = 0;
      err_m = 0;
    end else if (soft_reset) begin
      exp_q.delete();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue a whole packet into the FIFO and its predicted output into the scoreboard
  task automatic push_pkt(input logic [7:0] b[$]);
    exp_t       e;
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < b.size(); i++) begin
      if (i < b.size() - 1) acc = acc ^ b[i];
      e.data = b[i];
      e.sop  = (i == 0);
      e.eop  = (i == b.size() - 1);
      e.perr = (i == b.size() - 1) && (acc != b[i]);
      e.len  = b[0][7:2];
      exp_q.push_back(e);
      pend_q.push_back(b[i]);
    end
  endtask

  task automatic push_rand();
    logic [7:0] q[$];
    logic [7:0] par;
    int         len;
    len = $urandom_range(0, 15);
    q.push_back({6'(len), 2'($urandom_range(0, 3))});
    par = q[0];
    for (int i = 0; i < len; i++) begin
      q.push_back(8'($urandom_range(0, 255)));
      par = par ^ q[i + 1];
    end
    if ($urandom_range(0, 3) == 0) par = par ^ 8'(1 << $urandom_range(0, 7));
    q.push_back(par);
    push_pkt(q);
  endtask

  task automatic drain(input int budget, input bit rnd);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      if (rnd) begin
        stall      = ($urandom_range(0, 3) == 0);
        gate       = ($urandom_range(0, 4) != 0);
        soft_reset = ($urandom_range(0, 79) == 0);
      end
      n++;
    end
    if (n >= budget) chk("drain_timeout", exp_q.size(), 0);
    soft_reset = 1'b0;
    stall      = 1'b0;
    gate       = 1'b1;
    repeat (3) step();
  endtask

  task automatic wait_reads(input int base, input int target);
    int n;
    n = 0;
    while ((rd_cnt - base) < target && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("read_timeout", rd_cnt - base, target);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(bus8.rd_en), 0);
    chk({tag, "_data"}, 32'(bus8.pkt_data), 0);
    chk({tag, "_vld"}, 32'(bus8.pkt_data_vld), 0);
    chk({tag, "_frame"}, 32'({bus8.pkt_sop, bus8.pkt_eop, bus8.parity_err}), 0);
    chk({tag, "_len"}, 32'(bus8.pkt_len), 0);
    chk({tag, "_cnt8"}, 32'({bus8.pkt_cnt, bus8.err_cnt}), 0);
    chk({tag, "_cnt2"}, 32'({bus2.pkt_cnt, bus2.err_cnt}), 0);
    chk({tag, "_w2"}, 32'({bus2.rd_en, bus2.pkt_data_vld, bus2.pkt_data}), 0);
  endtask

  initial begin
    int base;
    int cnt_before;
    rst        = 1'b0;
    soft_reset = 1'b0;
    stall      = 1'b0;
    gate       = 1'b1;
    repeat (3) step();
    check_zero("reset");
    rst = 1'b1;
    repeat (2) step();

    // Basic packet
    base = rd_cnt;
    pb = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    push_pkt(pb);
    drain(200, 1'b0);
    chk("basic_rd_count", rd_cnt - base, 5);
    chk("basic_len", 32'(bus8.pkt_len), 3);
    chk("basic_cnt", 32'(bus8.pkt_cnt), 1);
    chk("basic_err", 32'(bus8.err_cnt), 0);

    // Bad parity
    pb = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0C};
    push_pkt(pb);
    drain(200, 1'b0);
    chk("badpar_cnt", 32'(bus8.pkt_cnt), 2);
    chk("badpar_err", 32'(bus8.err_cnt), 1);

    // Zero-length packet
    pb = '{8'h02, 8'h02};
    push_pkt(pb);
    drain(200, 1'b0);
    chk("len0_len", 32'(bus8.pkt_len), 0);
    chk("len0_cnt", 32'(bus8.pkt_cnt), 3);
    chk("len0_err", 32'(bus8.err_cnt), 1);

    // Backpressure then an empty gap mid-payload
    base = rd_cnt;
    pb = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    push_pkt(pb);
    wait_reads(base, 2);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_no_rd", 32'(bus8.rd_en), 0);
    end
    stall = 1'b0;
    step();
    gate = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("empty_no_rd", 32'(bus8.rd_en), 0);
    end
    gate = 1'b1;
    drain(200, 1'b0);
    chk("bp_rd_count", rd_cnt - base, 5);
    chk("bp_cnt", 32'(bus8.pkt_cnt), 4);

    // Abort after the second payload byte has been requested
    cnt_before = cnt_m;
    base = rd_cnt;
    pb = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    push_pkt(pb);
    wait_reads(base, 3);
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    repeat (10) step();
    chk("abort_cnt", 32'(bus8.pkt_cnt), 32'(cnt_before));
    chk("abort_err", 32'(bus8.err_cnt), 1);
    pb = '{8'h06, 8'hAA, 8'hAC};
    push_pkt(pb);
    drain(200, 1'b0);
    chk("post_abort_cnt", 32'(bus8.pkt_cnt), 32'(cnt_before + 1));
    chk("post_abort_err", 32'(bus8.err_cnt), 1);
    chk("post_abort_len", 32'(bus8.pkt_len), 1);

    // Counter saturation on the 2-bit instance
    for (int i = 0; i < 5; i++) begin
      pb = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
      push_pkt(pb);
      drain(200, 1'b0);
    end
    chk("sat_cnt2", 32'(bus2.pkt_cnt), 3);
    chk("sat_cnt8", 32'(bus8.pkt_cnt), 32'(cnt_before + 6));

    // Reset pulse in the middle of a packet
    pb = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    push_pkt(pb);
    repeat (5) step();
    rst = 1'b0;
    step();
    check_zero("midrst");
    rst = 1'b1;
    repeat (3) step();

    // Randomized traffic with stalls, empty gaps and aborts
    for (int k = 0; k < 120; k++) begin
      push_rand();
      if ($urandom_range(0, 1) == 1) push_rand();
      drain(800, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
